sram_like_lat_ram: RTL and testbench

- Synthesizable sram-like responder (slave) for the core's inst/data sram-like master ports.
- Word-organized RAM with byte-lane writes.
- Accepts pipelined requests, queues them, and returns data_ok strictly in order after a fixed programmable latency.
- Used as the latency-stressing memory in simulation and FPGA bring-up, in place of the zero-wait ROM/RAM models.

---
 rtl/sram_like_lat_ram.sv | 74 +++++++
 tb/tb_sram_like_lat_ram.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sram_like_lat_ram.sv
// sram_like_lat_ram: sram-like slave RAM with byte lanes, answering in order after a fixed LATENCY.
// Define SRAM_LIKE_STALL_EN to add LFSR-driven random addr_ok stalls.
module sram_like_lat_ram #(
   parameter int ADDR_WIDTH  = 10,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        addr_ok,
   output logic        data_ok
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   logic [31:0] mem [2**ADDR_WIDTH];
   logic [31:0] q_rdata_q [QUEUE_DEPTH];
   logic [3:0]  q_cd_q [QUEUE_DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [PW:0] count_q;
   logic rst_q, data_ok_q, stall, acc, pop, unused_addr;
   logic [31:0] rdata_q;
   logic [ADDR_WIDTH-1:0] idx;
   logic [3:0] lanes;
`ifdef SRAM_LIKE_STALL_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk)
      lfsr_q <= rst ? 16'hACE1 : {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign stall = lfsr_q[1:0] == 2'b00;
`else
   assign stall = 1'b0;
`endif
   assign unused_addr = ^addr[31:ADDR_WIDTH+2];
   assign idx     = addr[ADDR_WIDTH+1:2];
   assign lanes   = size == 2'd0 ? 4'b0001 << addr[1:0] :
                    size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   // count below depth is just the top bit clear since depth is a power of two
   assign addr_ok = !rst_q && !count_q[PW] && !stall;
   assign acc     = req && addr_ok && !rst;
   assign pop     = count_q != '0 && q_cd_q[head_q] == 4'd0;
   assign rdata   = rdata_q;
   assign data_ok = data_ok_q;
   always_ff @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (acc && wr && lanes[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
         if (q_cd_q[i] != 4'd0) q_cd_q[i] <= q_cd_q[i] - 4'd1;
      if (acc) begin
         q_rdata_q[tail_q] <= wr ? 32'd0 : mem[idx];
         q_cd_q[tail_q]    <= 4'(LATENCY - 1);
      end
   end
   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         head_q    <= head_q + PW'(pop);
         tail_q    <= tail_q + PW'(acc);
         count_q   <= count_q + (PW+1)'(acc) - (PW+1)'(pop);
         data_ok_q <= pop;
         rdata_q   <= pop ? q_rdata_q[head_q] : 32'd0;
      end
   end
endmodule

// File: tb/tb_sram_like_lat_ram.sv
// tb_sram_like_lat_ram: directed checks of latency, lanes, queue-full, reset on LATENCY 1/2/6 instances.
module tb_sram_like_lat_ram;
   logic clk = 1'b0, rst = 1'b1, wr = 1'b0;
   logic [1:0] size = 2'd0;
   logic [31:0] addr = '0, wdata = '0;
   logic [2:0] reqv = '0, aok, dok;
   logic [31:0] rd [3];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   sram_like_lat_ram #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .req(reqv[0]), .wr(wr), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rd[0]), .addr_ok(aok[0]), .data_ok(dok[0]));
   sram_like_lat_ram #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .req(reqv[1]), .wr(wr), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rd[1]), .addr_ok(aok[1]), .data_ok(dok[1]));
   sram_like_lat_ram #(.LATENCY(6)) u_l6 (.clk(clk), .rst(rst), .req(reqv[2]), .wr(wr), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rd[2]), .addr_ok(aok[2]), .data_ok(dok[2]));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic xfer(input int u, input int lat, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
      int n = 0;
      wr = w; size = s; addr = a; wdata = d; reqv[u] = 1'b1;
      while (!aok[u] && n < 20) begin step(); n++; end
      step();
      reqv[u] = 1'b0;
      n = 0;
      while (!dok[u] && n < 20) begin step(); n++; end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_rdata"}, rd[u], exp);
   endtask
   initial begin
      logic [7:0] dh, ah;
      logic [19:0] fh;
      logic [31:0] dr [8];
      int i, nd;
      logic a;
      step(); step();
      chk("rst_aok", {29'd0, aok}, 0);
      chk("rst_dok", {29'd0, dok}, 0);
      chk("rst_rdata", rd[2], 0);
      rst = 1'b0;
      chk("aok_first_cycle_after_rst", aok[1], 0);
      step();
      chk("aok_rise", aok[1], 1);
      xfer(1, 2, 1'b1, 2'd2, 32'h100, 32'h11223344, 32'h0, "l2_sw");
      xfer(1, 2, 1'b0, 2'd2, 32'h100, 32'h0, 32'h11223344, "l2_lw");
      xfer(1, 2, 1'b1, 2'd2, 32'h200, 32'h0, 32'h0, "sw_zero");
      xfer(1, 2, 1'b1, 2'd0, 32'h201, 32'h0000AA00, 32'h0, "sb");
      xfer(1, 2, 1'b1, 2'd1, 32'h202, 32'hBEEF0000, 32'h0, "sh_hi");
      xfer(1, 2, 1'b0, 2'd2, 32'h200, 32'h0, 32'hBEEFAA00, "lw_mixed");
      xfer(1, 2, 1'b1, 2'd1, 32'h201, 32'h00001234, 32'h0, "sh_lo_odd");
      xfer(1, 2, 1'b0, 2'd2, 32'h200, 32'h0, 32'hBEEF1234, "lw_half");
      xfer(1, 2, 1'b1, 2'd3, 32'h300, 32'hCAFEF00D, 32'h0, "size3_w");
      xfer(1, 2, 1'b0, 2'd2, 32'h10000300, 32'h0, 32'hCAFEF00D, "alias_r");
      // write then read of the same word on consecutive edges
      wr = 1'b1; size = 2'd2; addr = 32'h104; wdata = 32'h5A5A5A5A; reqv[1] = 1'b1;
      step();
      wr = 1'b0;
      step();
      reqv[1] = 1'b0;
      chk("raw_gap_dok", dok[1], 0);
      step();
      chk("raw_w_dok", dok[1], 1);
      chk("raw_w_rdata", rd[1], 0);
      step();
      chk("raw_r_dok", dok[1], 1);
      chk("raw_r_rdata", rd[1], 32'h5A5A5A5A);
      step();
      chk("raw_end_dok", dok[1], 0);
      xfer(0, 1, 1'b1, 2'd2, 32'h0, 32'd1, 32'h0, "l1_w0");
      xfer(0, 1, 1'b1, 2'd2, 32'h4, 32'd2, 32'h0, "l1_w4");
      xfer(0, 1, 1'b1, 2'd2, 32'h8, 32'd3, 32'h0, "l1_w8");
      step();
      wr = 1'b0; size = 2'd2;
      for (int k = 0; k < 8; k++) begin
         dh[k] = dok[0];
         dr[k] = rd[0];
         reqv[0] = k < 3;
         addr = 32'(4 * k);
         step();
      end
      chk("l1_dok_pattern", {24'd0, dh}, 32'h1C);
      chk("l1_rd0", dr[2], 1);
      chk("l1_rd1", dr[3], 2);
      chk("l1_rd2", dr[4], 3);
      for (int k = 0; k < 5; k++)
         xfer(2, 6, 1'b1, 2'd2, 32'(4 * k), 32'h600 + 32'(k), 32'h0, "l6_pre");
      step();
      wr = 1'b0; i = 0; nd = 0; fh = '0; ah = '0;
      for (int k = 0; k < 20; k++) begin
         if (k < 8) ah[k] = aok[2];
         fh[k] = dok[2];
         if (dok[2]) begin
            chk("full_rdata_order", rd[2], 32'h600 + 32'(nd));
            nd++;
         end
         reqv[2] = i < 5;
         addr = 32'(4 * i);
         a = reqv[2] && aok[2];
         step();
         if (a) i++;
      end
      reqv[2] = 1'b0;
      chk("full_aok_pattern", {24'd0, ah}, 32'h8F);
      chk("full_dok_pattern", {12'd0, fh}, 32'h4780);
      chk("full_accepts", i, 5);
      wr = 1'b0; reqv[2] = 1'b1;
      addr = 32'h0; step();
      addr = 32'h4; step();
      addr = 32'h8; step();
      reqv[2] = 1'b0;
      rst = 1'b1;
      step();
      chk("midrst_aok", aok[2], 0);
      chk("midrst_dok", dok[2], 0);
      chk("midrst_rdata", rd[2], 0);
      step();
      chk("midrst_aok2", aok[2], 0);
      rst = 1'b0;
      chk("midrst_aok_after", aok[2], 0);
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (dok[2]) nd++;
      end
      chk("midrst_no_dok", nd, 0);
      xfer(2, 6, 1'b0, 2'd2, 32'h8, 32'h0, 32'h602, "ram_kept_l6");
      xfer(1, 2, 1'b0, 2'd2, 32'h200, 32'h0, 32'hBEEF1234, "ram_kept_l2");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
